// File: rtl/mem_port_arbiter.sv
// Two-master arbiter in front of the single-port memory: load/store has priority,
// a starvation counter forces fetch through after STARVE_LIMIT denied cycles.
module mem_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic {NORMAL, FORCE_IF} state_t;

  localparam logic [3:0] CNT_MAX = 4'(STARVE_LIMIT - 1);

  state_t            r_state;
  logic [3:0]        r_starve_cnt;
  logic              r_if_rvalid;
  logic              r_ls_rvalid;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_ls_rdata;

  logic              w_if_win;
  logic              w_if_gnt;
  logic              w_ls_gnt;

  // Grants are gated by rst_n so nothing reaches the memory while reset is low.
  always_comb begin
    w_if_win = if_req && ((r_state == FORCE_IF) || !ls_req);
    w_if_gnt = rst_n && w_if_win;
    w_ls_gnt = rst_n && ls_req && !w_if_win;
  end

  assign if_gnt          = w_if_gnt;
  assign ls_gnt          = w_ls_gnt;
  assign mem_access_addr = w_ls_gnt ? ls_addr : if_addr;
  assign mem_write_data  = ls_wdata;
  assign mem_write_en    = w_ls_gnt && ls_we;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= NORMAL;
      r_starve_cnt <= '0;
      r_if_rvalid  <= 1'b0;
      r_ls_rvalid  <= 1'b0;
      r_if_rdata   <= '0;
      r_ls_rdata   <= '0;
    end else begin
      // A denied fetch counts up; any grant or dropped request restarts the count.
      if (if_req && !w_if_gnt) begin
        if (r_starve_cnt != CNT_MAX) begin
          r_starve_cnt <= r_starve_cnt + 4'd1;
        end
        if ((r_state == NORMAL) && (r_starve_cnt == CNT_MAX)) begin
          r_state <= FORCE_IF;
        end
      end else begin
        r_starve_cnt <= '0;
        r_state      <= NORMAL;
      end

      r_if_rvalid <= w_if_gnt;
      if (w_if_gnt) begin
        r_if_rdata <= mem_read_data;
      end

      r_ls_rvalid <= w_ls_gnt && !ls_we;
      if (w_ls_gnt && !ls_we) begin
        r_ls_rdata <= mem_read_data;
      end
    end
  end

  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign ls_rvalid = r_ls_rvalid;
  assign ls_rdata  = r_ls_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter with a behavioural memory and a
// transaction-level reference model of arbitration, starvation and read return.
module tb_mem_port_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [15:0] if_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [15:0] ls_addr;
  logic [15:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [15:0] ls_rdata;
  logic [15:0] mem_access_addr;
  logic [15:0] mem_write_data;
  logic        mem_write_en;
  logic [15:0] mem_read_data;

  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int          waited;
  bit          exp_if_rv, exp_ls_rv;
  logic [15:0] exp_if_rd, exp_ls_rd;
  bit          m_if_gnt, m_ls_gnt;
  bit          s_if_gnt;

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_access_addr];

  mem_port_arbiter #(
    .ADDR_W      (16),
    .DATA_W      (16),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_gnt         (if_gnt),
    .if_rvalid      (if_rvalid),
    .if_rdata       (if_rdata),
    .ls_req         (ls_req),
    .ls_we          (ls_we),
    .ls_addr        (ls_addr),
    .ls_wdata       (ls_wdata),
    .ls_gnt         (ls_gnt),
    .ls_rvalid      (ls_rvalid),
    .ls_rdata       (ls_rdata),
    .mem_access_addr(mem_access_addr),
    .mem_write_data (mem_write_data),
    .mem_write_en   (mem_write_en),
    .mem_read_data  (mem_read_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive, compare against the model, clock, update memory and model.
  task automatic step(input bit rst, input bit ireq, input logic [15:0] iaddr,
                      input bit lreq, input bit lwe, input logic [15:0] laddr,
                      input logic [15:0] ldata);
    bit          p_if, p_ls, p_we, wr_en;
    logic [15:0] p_addr, wr_a, wr_d;
    @(negedge clk);
    rst_n    = rst;
    if_req   = ireq;
    if_addr  = iaddr;
    ls_req   = lreq;
    ls_we    = lwe;
    ls_addr  = laddr;
    ls_wdata = ldata;
    #1;
    check("if_rvalid", 32'(if_rvalid), 32'(exp_if_rv));
    check("if_rdata",  32'(if_rdata),  32'(exp_if_rd));
    check("ls_rvalid", 32'(ls_rvalid), 32'(exp_ls_rv));
    check("ls_rdata",  32'(ls_rdata),  32'(exp_ls_rd));

    p_if = 1'b0;
    p_ls = 1'b0;
    if (rst) begin
      if (ireq && (waited >= STARVE_LIMIT || !lreq)) p_if = 1'b1;
      else if (lreq)                                  p_ls = 1'b1;
    end
    p_we   = p_ls && lwe;
    p_addr = p_ls ? laddr : iaddr;

    check("if_gnt",     32'(if_gnt),          32'(p_if));
    check("ls_gnt",     32'(ls_gnt),          32'(p_ls));
    check("both_gnt",   32'(if_gnt & ls_gnt), 32'(0));
    check("mem_we",     32'(mem_write_en),    32'(p_we));
    check("mem_addr",   32'(mem_access_addr), 32'(p_addr));
    check("mem_wdata",  32'(mem_write_data),  32'(ldata));
    s_if_gnt = if_gnt;

    wr_en = mem_write_en;
    wr_a  = mem_access_addr;
    wr_d  = mem_write_data;
    @(posedge clk);
    #1;
    if (wr_en) mem[wr_a] = wr_d;

    if (!rst) begin
      waited    = 0;
      exp_if_rv = 1'b0;
      exp_ls_rv = 1'b0;
      exp_if_rd = '0;
      exp_ls_rd = '0;
    end else begin
      exp_if_rv = p_if;
      if (p_if) exp_if_rd = ref_mem[p_addr];
      exp_ls_rv = p_ls && !lwe;
      if (p_ls && !lwe) exp_ls_rd = ref_mem[p_addr];
      if (p_we) ref_mem[p_addr] = ldata;
      waited = (ireq && !p_if) ? waited + 1 : 0;
    end
    m_if_gnt = p_if;
    m_ls_gnt = p_ls;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  function automatic logic [15:0] pick_addr();
    if ($urandom_range(7) == 0) return 16'hFFFF;
    return 16'($urandom_range(15));
  endfunction

  initial begin
    int          cnt;
    bit          if_p, ls_p, l_we;
    logic [15:0] i_a, l_a, l_d;
    bit          r;

    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 16'(i * 7 + 3);
      ref_mem[i] = 16'(i * 7 + 3);
    end
    waited = 0; exp_if_rv = 0; exp_ls_rv = 0; exp_if_rd = '0; exp_ls_rd = '0;
    rst_n = 1'b0; if_req = 1'b1; if_addr = 16'h0; ls_req = 1'b1; ls_we = 1'b1;
    ls_addr = 16'h0; ls_wdata = 16'h0;
    @(posedge clk);

    // Reset with both requests high and a store presented
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h0005, 1'b1, 1'b1, 16'h0006, 16'hAAAA);
    check("rst_nowrite0", 32'(mem[16'h0006]), 32'(16'h0006 * 7 + 3));

    // Fetch only
    mem[16'h0010] = 16'hBEEF;
    ref_mem[16'h0010] = 16'hBEEF;
    step(1'b1, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000);
    idle();
    check("fetch_rdata", 32'(if_rdata), 32'(16'hBEEF));

    // Store then load at the top address
    step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 16'h1234);
    step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 16'h0000);
    idle();
    check("raw_rdata", 32'(ls_rdata), 32'(16'h1234));

    // Continuous contention: fetch gets one slot in every STARVE_LIMIT+1
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 16'h0003, 1'b1, 1'b0, 16'h0004, 16'h0000);
      cnt += int'(s_if_gnt);
    end
    check("contend_if_cnt", 32'(cnt), 32'(2));
    idle();

    // Starvation clear: dropping if_req restarts the wait
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 16'h0007, 1'b1, 1'b0, 16'h0008, 16'h0);
    step(1'b1, 1'b0, 16'h0007, 1'b1, 1'b0, 16'h0008, 16'h0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 16'h0007, 1'b1, 1'b0, 16'h0008, 16'h0);
      cnt += int'(s_if_gnt);
    end
    check("starve_clear_wait", 32'(cnt), 32'(0));
    step(1'b1, 1'b1, 16'h0007, 1'b1, 1'b0, 16'h0008, 16'h0);
    check("starve_clear_gnt", 32'(s_if_gnt), 32'(1));
    idle();

    // Reset right after a load grant, with a store presented during reset
    step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'h0000);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0020, 16'hDEAD);
    check("rst_nowrite1", 32'(mem[16'h0020]), 32'(ref_mem[16'h0020]));
    step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'h0000);
    idle();

    // Randomized traffic honouring the hold-until-grant protocol
    if_p = 0; ls_p = 0; i_a = '0; l_a = '0; l_d = '0; l_we = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!if_p && $urandom_range(3) != 0) begin
        if_p = 1; i_a = pick_addr();
      end
      if (!ls_p && $urandom_range(3) != 0) begin
        ls_p = 1; l_a = pick_addr(); l_we = 1'($urandom_range(1)); l_d = 16'($urandom);
      end
      r = ($urandom_range(99) != 0);
      step(r, if_p, i_a, ls_p, l_we, l_a, l_d);
      if (m_if_gnt) if_p = 0;
      if (m_ls_gnt) ls_p = 0;
    end
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
